and_or: RTL and testbench

//  Bitwise combinational gate Q = (A AND B) OR C on WIDTH-bit lanes.

---
 rtl/and_or_pkg.sv | 11 +
 rtl/and_or_lane.sv | 11 +
 rtl/and_or.sv | 59 +++++
 tb/tb_and_or.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/and_or_pkg.sv
// Shared types and helpers for the and_or glue gate.
package and_or_pkg;

  typedef logic [2:0] cov_idx_t;

  // Coverage slot for one lane's input triple, A as the MSB.
  function automatic cov_idx_t cov_index(input logic a, input logic b, input logic c);
    return {a, b, c};
  endfunction

endpackage

// File: rtl/and_or_lane.sv
// One bit lane of the (A & B) | C gate.
module and_or_lane (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic q
);

  assign q = (a & b) | c;

endmodule

// File: rtl/and_or.sv
// Bitwise (A & B) | C gate with a one-cycle registered copy and sticky lane-0 truth-table coverage.
module and_or
  import and_or_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] q_reg,
  output logic             out_valid,
  output logic [7:0]       cov,
  output logic             cov_full
);

  localparam int unsigned COV_W = 8;

  logic [COV_W-1:0] cov_q;

  // Independent combinational lanes.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    and_or_lane u_lane (
      .a (A[i]),
      .b (B[i]),
      .c (C[i]),
      .q (Q[i])
    );
  end

  // Registered copy: q_reg holds across invalid cycles, out_valid tracks in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        q_reg <= Q;
      end
      out_valid <= in_valid;
    end
  end

  // Sticky coverage of lane-0 input combinations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cov_q <= '0;
    end else if (in_valid) begin
      cov_q[cov_index(A[0], B[0], C[0])] <= 1'b1;
    end
  end

  assign cov      = cov_q;
  assign cov_full = &cov_q;

endmodule

// File: tb/tb_and_or.sv
// Randomized and directed bench for and_or at WIDTH=1 and WIDTH=8.
module tb_and_or;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [0:0] a1, b1, c1, q1, qr1;
  logic       v1, ov1, cf1;
  logic [7:0] cov1;

  logic [7:0] a8, b8, c8, q8, qr8;
  logic       v8, ov8, cf8;
  logic [7:0] cov8;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic       m_qr1;
  logic [7:0] m_qr8;
  logic       m_ov1, m_ov8;
  logic [7:0] m_cov1, m_cov8;

  and_or #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .in_valid(v1),
    .Q(q1), .q_reg(qr1), .out_valid(ov1), .cov(cov1), .cov_full(cf1)
  );

  and_or #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .in_valid(v8),
    .Q(q8), .q_reg(qr8), .out_valid(ov8), .cov(cov8), .cov_full(cf8)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-lane truth: a lane is 1 when both A and B are 1, or C is 1.
  function automatic logic [7:0] gate_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input int w);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < w; i++) begin
      r[i] = ((int'(a[i]) + int'(b[i])) == 2) || (c[i] == 1'b1);
    end
    return r;
  endfunction

  function automatic int slot(input logic a, input logic b, input logic c);
    return int'(a) * 4 + int'(b) * 2 + int'(c);
  endfunction

  task automatic model_reset();
    m_qr1 = 1'b0; m_qr8 = '0;
    m_ov1 = 1'b0; m_ov8 = 1'b0;
    m_cov1 = '0;  m_cov8 = '0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_q1"},   8'(q1),  gate_ref(8'(a1), 8'(b1), 8'(c1), 1));
    check({tag, "_qr1"},  8'(qr1), 8'(m_qr1));
    check({tag, "_ov1"},  8'(ov1), 8'(m_ov1));
    check({tag, "_cov1"}, cov1,    m_cov1);
    check({tag, "_cf1"},  8'(cf1), 8'(m_cov1 == 8'hFF));
    check({tag, "_q8"},   q8,      gate_ref(a8, b8, c8, 8));
    check({tag, "_qr8"},  qr8,     m_qr8);
    check({tag, "_ov8"},  8'(ov8), 8'(m_ov8));
    check({tag, "_cov8"}, cov8,    m_cov8);
    check({tag, "_cf8"},  8'(cf8), 8'(m_cov8 == 8'hFF));
  endtask

  // One rising edge; inputs are stable from #1 after the previous edge.
  task automatic step(input string tag);
    logic [7:0] n1, n8;
    int s1, s8;
    n1 = gate_ref(8'(a1), 8'(b1), 8'(c1), 1);
    n8 = gate_ref(a8, b8, c8, 8);
    s1 = slot(a1[0], b1[0], c1[0]);
    s8 = slot(a8[0], b8[0], c8[0]);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (v1) begin m_qr1 = n1[0]; m_cov1[s1] = 1'b1; end
      if (v8) begin m_qr8 = n8;    m_cov8[s8] = 1'b1; end
      m_ov1 = v1;
      m_ov8 = v8;
    end
    #1;
    check_all(tag);
  endtask

  task automatic set1(input int abc, input logic v);
    logic [2:0] t;
    t = 3'(abc);
    a1 = t[2]; b1 = t[1]; c1 = t[0]; v1 = v;
  endtask

  initial begin
    logic [7:0] tt;
    rst = 1'b1;
    a1 = '0; b1 = '0; c1 = '0; v1 = 1'b0;
    a8 = '0; b8 = '0; c8 = '0; v8 = 1'b0;
    model_reset();
    #3;
    check_all("reset");

    // Exhaustive WIDTH=1 truth table while held in reset with in_valid high.
    tt = 8'b1110_1010;
    for (int i = 0; i < 8; i++) begin
      set1(i, 1'b1);
      #10;
      check($sformatf("tt%0d", i), 8'(q1), 8'(tt[i]));
    end
    check("rst_ignores_valid_cov", cov1, 8'h00);
    check("rst_ignores_valid_ov", 8'(ov1), 8'h00);
    v1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Registered path
    set1(3'b110, 1'b1);
    step("reg1");
    check("reg_q", 8'(qr1), 8'h01);
    check("reg_ov", 8'(ov1), 8'h01);
    set1(3'b000, 1'b0);
    step("reg2");
    check("hold_q", 8'(qr1), 8'h01);
    check("hold_ov", 8'(ov1), 8'h00);

    // Coverage: clear, then only 000 and 111, then every combination
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    model_reset();
    set1(0, 1'b1); step("cov000");
    set1(7, 1'b1); step("cov111");
    set1(7, 1'b1); step("cov111r");
    check("cov_81", cov1, 8'h81);
    for (int i = 0; i < 8; i++) begin
      set1(i, 1'b1);
      step($sformatf("covall%0d", i));
    end
    check("cov_ff", cov1, 8'hFF);
    check("cov_full", 8'(cf1), 8'h01);
    check("pre_rst_q", 8'(qr1), 8'h01);

    // Async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_qr", 8'(qr1), 8'h00);
    check("async_ov", 8'(ov1), 8'h00);
    check("async_cov", cov1, 8'h00);
    check("async_cf", 8'(cf1), 8'h00);
    check("async_q_kept", 8'(q1), 8'h01);
    model_reset();
    check_all("async");
    rst = 1'b0;

    // WIDTH=8 directed
    set1(0, 1'b0);
    a8 = 8'hF0; b8 = 8'hCC; c8 = 8'h01; v8 = 1'b1;
    #1;
    check("w8_q", q8, 8'hC1);
    step("w8");
    check("w8_qr", qr8, 8'hC1);
    check("w8_ov", 8'(ov8), 8'h01);

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 300; n++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v1 = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      step("rnd");
      if (n % 37 == 36) begin
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        rst = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
